reorder_buffer: RTL

- Circular in-order reorder buffer between the decoder/CDB and the regfile.
- Allocates a ROB tag per issued instruction and captures results broadcast on the CDB.
- Retires at most one instruction per cycle from the head, writing the regfile commit port.
- Raises a one-cycle flush when a mispredicted branch retires, and supplies the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 22 ++
 rtl/rob_ptr.sv | 22 ++
 rtl/reorder_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and pointer helper for the reorder buffer.
// Optional build macro in the top: ROB_CDB_BYPASS_EN.
package reorder_buffer_pkg;

    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned DEPTH     = 1 << ROB_WIDTH;
    localparam int unsigned ROB_RANGE = DEPTH;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned DATA_W    = 32;

    typedef logic [ROB_WIDTH-1:0] rob_tag_t;

    localparam rob_tag_t          ROB_TAG_NONE  = rob_tag_t'(0);
    localparam rob_tag_t          ROB_TAG_FIRST = rob_tag_t'(1);
    localparam logic [REG_W-1:0]  REG_ZERO      = REG_W'(0);

    // Tag 0 is reserved, so the pointer wraps from DEPTH-1 back to 1.
    function automatic rob_tag_t rob_next(input rob_tag_t p);
        return (p == rob_tag_t'(DEPTH - 1)) ? ROB_TAG_FIRST : p + rob_tag_t'(1);
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Circular ROB pointer that skips tag 0; resets and clears to tag 1.
module rob_ptr
    import reorder_buffer_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clr,
    input  logic                 adv,
    output logic [ROB_WIDTH-1:0] ptr
);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ptr <= ROB_TAG_FIRST;
        end else if (clr) begin
            ptr <= ROB_TAG_FIRST;
        end else if (adv) begin
            ptr <= rob_next(ptr);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, CDB capture, single retire, mispredict flush.
// Build option ROB_CDB_BYPASS_EN lets a CDB result for the head slot retire the same cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 from_decoder_valid,
    input  logic                 from_decoder_has_rd,
    input  logic [4:0]           from_decoder_rd,
    input  logic                 from_decoder_is_branch,
    output logic [ROB_WIDTH-1:0] to_decoder_rob_id,
    output logic                 to_decoder_full,
    input  logic                 from_cdb_valid,
    input  logic [ROB_WIDTH-1:0] from_cdb_rob_id,
    input  logic [31:0]          from_cdb_value,
    input  logic                 from_cdb_mispredict,
    input  logic [31:0]          from_cdb_redirect_pc,
    input  logic [ROB_WIDTH-1:0] from_rf_cur_rob_id,
    output logic                 to_rf_write_enabled,
    output logic [4:0]           to_rf_reg_id,
    output logic [31:0]          to_rf_data,
    output logic [ROB_WIDTH-1:0] to_rf_rob_id,
    output logic                 flush_output,
    output logic [31:0]          to_if_redirect_pc
);

    logic [ROB_RANGE-1:0] busy_q;
    logic [ROB_RANGE-1:0] ready_q;
    logic [ROB_RANGE-1:0] has_rd_q;
    logic [ROB_RANGE-1:0] is_branch_q;
    logic [ROB_RANGE-1:0] mispredict_q;
    logic [REG_W-1:0]     rd_q          [ROB_RANGE];
    logic [DATA_W-1:0]    value_q       [ROB_RANGE];
    logic [DATA_W-1:0]    redirect_pc_q [ROB_RANGE];

    logic [ROB_WIDTH-1:0] count_q, count_d;
    rob_tag_t             head, tail;

    logic                 issue_c, cdb_hit_c, commit_c, mispredict_c;
    logic                 head_ready_c, head_mispredict_c;
    logic [DATA_W-1:0]    head_value_c, head_redirect_c;

    rob_ptr u_head (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (mispredict_c),
        .adv    (commit_c),
        .ptr    (head)
    );

    rob_ptr u_tail (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (mispredict_c),
        .adv    (issue_c),
        .ptr    (tail)
    );

    assign to_decoder_rob_id = tail;
    assign to_decoder_full   = (count_q == ROB_WIDTH'(DEPTH - 1));

    assign issue_c   = from_decoder_valid && !to_decoder_full && !flush_output;
    assign cdb_hit_c = from_cdb_valid && (from_cdb_rob_id != ROB_TAG_NONE)
                       && busy_q[from_cdb_rob_id] && !flush_output;

`ifdef ROB_CDB_BYPASS_EN
    logic bypass_c;
    assign bypass_c          = cdb_hit_c && (from_cdb_rob_id == head) && !ready_q[head];
    assign head_ready_c      = ready_q[head] || bypass_c;
    assign head_value_c      = bypass_c ? from_cdb_value       : value_q[head];
    assign head_mispredict_c = bypass_c ? from_cdb_mispredict  : mispredict_q[head];
    assign head_redirect_c   = bypass_c ? from_cdb_redirect_pc : redirect_pc_q[head];
`else
    assign head_ready_c      = ready_q[head];
    assign head_value_c      = value_q[head];
    assign head_mispredict_c = mispredict_q[head];
    assign head_redirect_c   = redirect_pc_q[head];
`endif

    assign commit_c     = (count_q != '0) && head_ready_c && !flush_output;
    assign mispredict_c = commit_c && is_branch_q[head] && head_mispredict_c;

    // Commit port; a younger rename of the same register keeps its tag in the regfile.
    always_comb begin
        to_rf_write_enabled = 1'b0;
        to_rf_reg_id        = REG_ZERO;
        to_rf_data          = '0;
        to_rf_rob_id        = ROB_TAG_NONE;
        if (commit_c) begin
            to_rf_write_enabled = has_rd_q[head] && (rd_q[head] != REG_ZERO);
            to_rf_reg_id        = rd_q[head];
            to_rf_data          = head_value_c;
            to_rf_rob_id        = (from_rf_cur_rob_id == head) ? ROB_TAG_NONE : from_rf_cur_rob_id;
        end
    end

    always_comb begin
        count_d = count_q;
        if (mispredict_c) begin
            count_d = '0;
        end else if (issue_c && !commit_c) begin
            count_d = count_q + ROB_WIDTH'(1);
        end else if (!issue_c && commit_c) begin
            count_d = count_q - ROB_WIDTH'(1);
        end
    end

    // Slot bookkeeping; payload arrays are datapath only and need no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q            <= '0;
            ready_q           <= '0;
            count_q           <= '0;
            flush_output      <= 1'b0;
            to_if_redirect_pc <= '0;
        end else begin
            count_q      <= count_d;
            flush_output <= mispredict_c;
            if (mispredict_c) begin
                to_if_redirect_pc <= head_redirect_c;
                busy_q            <= '0;
                ready_q           <= '0;
            end else begin
                if (cdb_hit_c) begin
                    ready_q[from_cdb_rob_id]       <= 1'b1;
                    value_q[from_cdb_rob_id]       <= from_cdb_value;
                    mispredict_q[from_cdb_rob_id]  <= from_cdb_mispredict;
                    redirect_pc_q[from_cdb_rob_id] <= from_cdb_redirect_pc;
                end
                if (issue_c) begin
                    busy_q[tail]       <= 1'b1;
                    ready_q[tail]      <= 1'b0;
                    has_rd_q[tail]     <= from_decoder_has_rd;
                    rd_q[tail]         <= from_decoder_rd;
                    is_branch_q[tail]  <= from_decoder_is_branch;
                    mispredict_q[tail] <= 1'b0;
                end
                if (commit_c) begin
                    busy_q[head]  <= 1'b0;
                    ready_q[head] <= 1'b0;
                end
            end
        end
    end

endmodule
